// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - status encodings and FSM state constants for the process sequencer
package proc_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_LOAD = 2'b10;
    localparam logic [1:0] ST_READ = 2'b11;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOAD      = 3'd1;
    localparam logic [2:0] HOLD      = 3'd2;
    localparam logic [2:0] RUN       = 3'd3;
    localparam logic [2:0] READ_ADDR = 3'd4;
    localparam logic [2:0] READ_WAIT = 3'd5;
    localparam logic [2:0] READ_OUT  = 3'd6;
    localparam logic [2:0] DONE      = 3'd7;

endpackage

// File: rtl/rd_lat_pipe.sv
// rtl/rd_lat_pipe.sv - RD_LAT-deep valid shift register timing data-memory read capture
module rd_lat_pipe #(
    parameter int RD_LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic launch,
    output logic ready
);

    logic [RD_LAT-1:0] pipe;

    generate
        if (RD_LAT == 1) begin : g_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pipe <= '0;
                end else if (clear) begin
                    pipe <= '0;
                end else begin
                    pipe <= launch;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pipe <= '0;
                end else if (clear) begin
                    pipe <= '0;
                end else begin
                    pipe <= {pipe[RD_LAT-2:0], launch};
                end
            end
        end
    endgenerate

    assign ready = pipe[RD_LAT-1];

endmodule

// File: rtl/process_sequencer.sv
// rtl/process_sequencer.sv - host-side sequencer driving the processor through LOAD, RUN and READ
module process_sequencer
    import proc_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int RD_LAT      = 2,
    parameter int RUN_TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] load_len,
    input  logic [ADDR_W-1:0] read_base,
    input  logic [ADDR_W-1:0] read_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              end_process,
    input  logic [DATA_W-1:0] dm_out,
    output logic [1:0]        status,
    output logic [DATA_W-1:0] data_in,
    output logic [ADDR_W-1:0] data_addr_in,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);

    logic [2:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       run_cnt;
    logic [ADDR_W-1:0] load_len_q;
    logic [ADDR_W-1:0] read_base_q;
    logic [ADDR_W-1:0] read_len_q;
    logic              rd_ready;
    logic              pipe_clear;
    logic              pipe_launch;

    // One token per issued address; it emerges when dm_out reflects that address.
    assign pipe_launch = (state == READ_ADDR);
    assign pipe_clear  = abort || (state == IDLE);

    rd_lat_pipe #(
        .RD_LAT(RD_LAT)
    ) u_rd_lat_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (pipe_clear),
        .launch(pipe_launch),
        .ready (rd_ready)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            status       <= ST_IDLE;
            data_in      <= '0;
            data_addr_in <= '0;
            in_ready     <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout_err  <= 1'b0;
            cnt          <= '0;
            idx          <= '0;
            run_cnt      <= '0;
            load_len_q   <= '0;
            read_base_q  <= '0;
            read_len_q   <= '0;
        end else if (abort) begin
            state     <= IDLE;
            status    <= ST_IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        load_len_q   <= load_len;
                        read_base_q  <= read_base;
                        read_len_q   <= read_len;
                        timeout_err  <= 1'b0;
                        cnt          <= '0;
                        idx          <= '0;
                        run_cnt      <= '0;
                        data_in      <= '0;
                        data_addr_in <= '0;
                        busy         <= 1'b1;
                        if (load_len != '0) begin
                            state    <= LOAD;
                            status   <= ST_LOAD;
                            in_ready <= 1'b1;
                        end else begin
                            state  <= RUN;
                            status <= ST_RUN;
                        end
                    end
                end
                LOAD: begin
                    if (in_valid && in_ready) begin
                        data_in      <= in_data;
                        data_addr_in <= cnt;
                        cnt          <= cnt + ADDR_W'(1);
                        if (cnt + ADDR_W'(1) == load_len_q) begin
                            in_ready <= 1'b0;
                            state    <= HOLD;
                        end
                    end
                end
                // status stays LOAD one more cycle so the final write lands in DM
                HOLD: begin
                    state   <= RUN;
                    status  <= ST_RUN;
                    run_cnt <= '0;
                end
                RUN: begin
                    run_cnt <= run_cnt + 32'd1;
                    if (end_process) begin
                        if (read_len_q != '0) begin
                            state        <= READ_ADDR;
                            status       <= ST_READ;
                            idx          <= '0;
                            data_addr_in <= read_base_q;
                        end else begin
                            state  <= DONE;
                            status <= ST_IDLE;
                            done   <= 1'b1;
                        end
                    end else if ((RUN_TIMEOUT != 0) && (run_cnt + 32'd1 == 32'(RUN_TIMEOUT))) begin
                        timeout_err <= 1'b1;
                        state       <= DONE;
                        status      <= ST_IDLE;
                        done        <= 1'b1;
                    end
                end
                READ_ADDR: begin
                    state <= READ_WAIT;
                end
                READ_WAIT: begin
                    if (rd_ready) begin
                        out_data  <= dm_out;
                        out_valid <= 1'b1;
                        state     <= READ_OUT;
                    end
                end
                READ_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        idx       <= idx + ADDR_W'(1);
                        if (idx + ADDR_W'(1) == read_len_q) begin
                            state  <= DONE;
                            status <= ST_IDLE;
                            done   <= 1'b1;
                        end else begin
                            data_addr_in <= read_base_q + idx + ADDR_W'(1);
                            state        <= READ_ADDR;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_process_sequencer.sv
// tb/tb_process_sequencer.sv - scoreboard bench for process_sequencer with a processor/DM model
module tb_process_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] load_len = '0;
    logic [15:0] read_base = '0;
    logic [15:0] read_len = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready = 1'b0;
    logic        end_process = 1'b0;
    logic [7:0]  dm_out = '0;
    logic [1:0]  status;
    logic [7:0]  data_in;
    logic [15:0] data_addr_in;
    logic        busy;
    logic        done;
    logic        timeout_err;

    int n_checks = 0;
    int n_fail = 0;

    logic [1:0]  exp_status[$];
    int          exp_run[$];
    logic [23:0] exp_rd[$];
    logic        exp_done[$];

    logic [7:0]  mem [0:65535];
    logic [15:0] addr_q = '0;
    logic        tb_we = 1'b0;
    logic [15:0] tb_wa = '0;
    logic [7:0]  tb_wd = '0;
    int          run_target = 0;
    int          ready_delay = 0;

    process_sequencer #(
        .ADDR_W(16), .DATA_W(8), .RD_LAT(2), .RUN_TIMEOUT(20)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .load_len(load_len), .read_base(read_base), .read_len(read_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .end_process(end_process), .dm_out(dm_out), .status(status),
        .data_in(data_in), .data_addr_in(data_addr_in), .busy(busy),
        .done(done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got unexpected event expected none", name);
    endtask

    // Processor model: LOAD writes, one address register, then a synchronous DM read
    always @(posedge clk) begin
        if (status == 2'b10) mem[data_addr_in] <= data_in;
        if (tb_we) mem[tb_wa] <= tb_wd;
        addr_q <= data_addr_in;
        dm_out <= mem[addr_q];
    end

    int rc = 0;
    always @(posedge clk) begin
        #2;
        if (status == 2'b01) begin
            rc++;
            end_process = (run_target != 0) && (rc >= run_target);
        end else begin
            rc = 0;
            end_process = 1'b0;
        end
    end

    int wait_cnt = 0;
    always @(posedge clk) begin
        #2;
        if (out_valid) begin
            if (wait_cnt < ready_delay) begin
                out_ready = 1'b0;
                wait_cnt++;
            end else begin
                out_ready = 1'b1;
            end
        end else begin
            wait_cnt = 0;
            out_ready = (ready_delay == 0);
        end
    end

    logic [1:0]  prev_st = 2'b00;
    int          run_len = 0;
    logic        hold_pend = 1'b0;
    logic [7:0]  held_d = '0;
    logic [15:0] held_a = '0;
    logic        prev_done = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (status != prev_st) begin
                if (exp_status.size() == 0) fail("status_unexpected");
                else check_eq("status_seq", 32'(status), 32'(exp_status.pop_front()));
                if (prev_st == 2'b01) begin
                    if (exp_run.size() == 0) fail("run_unexpected");
                    else check_eq("run_len", run_len, exp_run.pop_front());
                    run_len = 0;
                end
                prev_st = status;
            end
            if (status == 2'b01) run_len++;
            if (hold_pend)
                check_eq("out_hold", {7'd0, out_valid, out_data, data_addr_in}, {7'd0, 1'b1, held_d, held_a});
            hold_pend = out_valid && !out_ready;
            held_d = out_data;
            held_a = data_addr_in;
            if (out_valid && out_ready) begin
                if (exp_rd.size() == 0) fail("read_unexpected");
                else check_eq("read_addr_data", {8'd0, data_addr_in, out_data}, {8'd0, exp_rd.pop_front()});
            end
            if (prev_done) check_eq("done_width", 32'(done), 32'd0);
            if (done) begin
                if (exp_done.size() == 0) fail("done_unexpected");
                else check_eq("done_timeout_err", 32'(timeout_err), 32'(exp_done.pop_front()));
                check_eq("done_status", 32'(status), 32'd0);
            end
            prev_done = done;
        end
    end

    task automatic launch(input logic [15:0] ll, input logic [15:0] rb, input logic [15:0] rl,
                          input int rt, input int dly);
        load_len = ll;
        read_base = rb;
        read_len = rl;
        run_target = rt;
        ready_delay = dly;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data = b;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) fail("send_timeout");
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) fail("wait_idle_timeout");
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_eq("reset_ctrl", {26'd0, status, busy, done, timeout_err, in_ready},
                 32'd0);
        check_eq("reset_data", {out_valid, out_data, data_in, data_addr_in[14:0]}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Load 4, run 10, read 4 from base 0
        exp_status.push_back(2'b10); exp_status.push_back(2'b01);
        exp_status.push_back(2'b11); exp_status.push_back(2'b00);
        exp_run.push_back(10);
        for (int i = 0; i < 4; i++) exp_rd.push_back({16'(i), 8'(8'h11 * (i + 1))});
        exp_done.push_back(1'b0);
        launch(16'd4, 16'd0, 16'd4, 10, 0);
        for (int i = 0; i < 4; i++) send_byte(8'(8'h11 * (i + 1)));
        check_eq("load_last_addr", 32'(data_addr_in), 32'd3);
        wait_idle();

        // No load, no read, run 3
        exp_status.push_back(2'b01); exp_status.push_back(2'b00);
        exp_run.push_back(3);
        exp_done.push_back(1'b0);
        launch(16'd0, 16'd0, 16'd0, 3, 0);
        wait_idle();

        // Timeout after 20 RUN cycles, readout skipped
        exp_status.push_back(2'b01); exp_status.push_back(2'b00);
        exp_run.push_back(20);
        exp_done.push_back(1'b1);
        launch(16'd0, 16'd0, 16'd2, 0, 0);
        wait_idle();
        check_eq("timeout_sticky", 32'(timeout_err), 32'd1);

        // Readout with backpressure; also clears timeout_err on start
        exp_status.push_back(2'b01); exp_status.push_back(2'b11); exp_status.push_back(2'b00);
        exp_run.push_back(2);
        for (int i = 0; i < 4; i++) exp_rd.push_back({16'(i), 8'(8'h11 * (i + 1))});
        exp_done.push_back(1'b0);
        launch(16'd0, 16'd0, 16'd4, 2, 5);
        check_eq("timeout_cleared", 32'(timeout_err), 32'd0);
        wait_idle();

        // Address wrap FFFE, FFFF, 0000
        tb_we = 1'b1; tb_wa = 16'hFFFE; tb_wd = 8'hA1;
        @(negedge clk);
        tb_wa = 16'hFFFF; tb_wd = 8'hB2;
        @(negedge clk);
        tb_we = 1'b0;
        exp_status.push_back(2'b01); exp_status.push_back(2'b11); exp_status.push_back(2'b00);
        exp_run.push_back(1);
        exp_rd.push_back({16'hFFFE, 8'hA1});
        exp_rd.push_back({16'hFFFF, 8'hB2});
        exp_rd.push_back({16'h0000, 8'h11});
        exp_done.push_back(1'b0);
        launch(16'd0, 16'hFFFE, 16'd3, 1, 0);
        wait_idle();

        // Abort mid-LOAD after 2 of 8 beats, with an ignored start while busy
        exp_status.push_back(2'b10); exp_status.push_back(2'b00);
        launch(16'd8, 16'd0, 16'd2, 4, 0);
        send_byte(8'h51);
        load_len = 16'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_start_ignored", {29'd0, status, in_ready}, {29'd0, 2'b10, 1'b1});
        send_byte(8'h52);
        check_eq("pre_abort_addr", {8'd0, data_in, data_addr_in}, {8'd0, 8'h52, 16'd1});
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("abort_state", {27'd0, status, busy, in_ready, out_valid}, 32'd0);
        @(negedge clk);

        // Fresh job reloads from address 0
        exp_status.push_back(2'b10); exp_status.push_back(2'b01);
        exp_status.push_back(2'b11); exp_status.push_back(2'b00);
        exp_run.push_back(4);
        exp_rd.push_back({16'd0, 8'h61});
        exp_rd.push_back({16'd1, 8'h62});
        exp_done.push_back(1'b0);
        launch(16'd8, 16'd0, 16'd2, 4, 0);
        for (int i = 0; i < 8; i++) send_byte(8'(8'h61 + i));
        wait_idle();

        repeat (3) @(negedge clk);
        check_eq("queues_drained",
                 exp_status.size() + exp_run.size() + exp_rd.size() + exp_done.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/process_sequencer.md
Name: process_sequencer

Overview:
Host-side controller that sequences the processor through its three operating modes via the 2-bit `status` bus.
- LOAD (10): streams bytes into data memory.
- RUN (01): lets the processor execute until `end_process`.
- READ (11): streams result bytes back out of data memory.
Sits between the external host interface (valid/ready streams) and the processor's `status`, `data_in`, `data_addr_in`, `end_process` and `dm_out` pins.

Parameters:
ADDR_W, 16, width of data-memory address (`data_addr_in`, length and base fields)
DATA_W, 8, width of data-memory byte
RD_LAT, 2, cycles from `data_addr_in` change to valid `dm_out` (1 processor register + 1 sync DM read)
RUN_TIMEOUT, 65535, max RUN cycles before abort; 0 disables the timeout

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a job; sampled only in IDLE
abort  in  1  synchronous abort; return to IDLE from any state
load_len  in  ADDR_W  bytes to load at address 0; latched on start
read_base  in  ADDR_W  first readout address; latched on start
read_len  in  ADDR_W  bytes to read out; latched on start
in_valid  in  1  host write byte valid
in_data  in  DATA_W  host write byte
in_ready  out  1  sequencer accepts byte
out_valid  out  1  readout byte valid
out_data  out  DATA_W  readout byte
out_ready  in  1  host accepts readout byte
end_process  in  1  processor finished execution
dm_out  in  DATA_W  data-memory read data
status  out  2  processor mode: 00 idle, 01 run, 10 load, 11 read
data_in  out  DATA_W  byte to write into DM in LOAD
data_addr_in  out  ADDR_W  DM address in LOAD/READ
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on job completion
timeout_err  out  1  sticky; set on RUN timeout, cleared on next accepted start

Behaviour:
- Reset (async, rst_n=0): state IDLE; status=00; data_in=0; data_addr_in=0; in_ready=0; out_valid=0; out_data=0; busy=0; done=0; timeout_err=0; all counters 0.
- All outputs are registered.
- IDLE:
  - status=00.
  - start=1 latches load_len, read_base and read_len, clears timeout_err, clears counters.
  - Next state is LOAD if load_len≠0, else RUN.
- LOAD:
  - status=10; in_ready=1 while cnt<load_len.
  - On in_valid&&in_ready: data_in<=in_data; data_addr_in<=cnt; cnt++.
  - data_in/data_addr_in hold between beats; repeated processor writes of the same byte are harmless.
  - After the last beat, one HOLD cycle with status=10 and in_ready=0, so the processor captures the final write. Then go to RUN.
- RUN:
  - status=01; run counter increments each cycle.
  - end_process=1 -> READ if read_len≠0, else DONE.
  - If RUN_TIMEOUT≠0 and counter reaches RUN_TIMEOUT without end_process: timeout_err<=1, go to DONE, skip readout.
  - If end_process and timeout occur in the same cycle, end_process wins.
- READ:
  - status=11; data_addr_in=(read_base+idx) mod 2^ADDR_W.
  - After each address update, wait RD_LAT cycles, then out_data<=dm_out and out_valid<=1.
  - out_valid holds with stable out_data until out_ready.
  - On handshake: out_valid<=0, idx++, new address issued the next cycle.
  - After read_len handshakes -> DONE.
- DONE: done=1 for exactly one cycle; status=00; -> IDLE.
- start while busy: ignored.
- abort: next cycle state=IDLE, status=00, in_ready=0, out_valid=0. Any in-flight beat is dropped. abort has priority over all other transitions.
- Reset asserted mid-operation: immediate return to reset values.
- A value of 0 for load_len or read_len skips that phase. Maximum lengths are 2^ADDR_W−1.

Decomposition:
- Package `proc_pkg`: status encodings ST_IDLE=2'b00, ST_RUN=2'b01, ST_LOAD=2'b10, ST_READ=2'b11; FSM state enum {IDLE, LOAD, HOLD, RUN, READ_ADDR, READ_WAIT, READ_OUT, DONE}.
- One natural sub-module: `rd_lat_pipe`, an RD_LAT-deep valid shift register that times DM read capture.

Test Plan:
- Load 4 bytes {11,22,33,44}, end_process after 10 RUN cycles, read_base=0, read_len=4, out_ready=1 -> status sequence 10,01,11,00; out_data 11,22,33,44; done pulse once.
- load_len=0, read_len=0, end_process after 3 cycles -> status goes 00→01→00 with no LOAD/READ cycles; done pulse 1 cycle after end_process.
- RUN_TIMEOUT=20, end_process never asserted -> timeout_err=1 after 20 RUN cycles, no READ phase, done pulse; next start clears timeout_err.
- READ with out_ready low for 5 cycles per byte -> out_valid and out_data held stable; no address advance; all bytes delivered in order.
- read_base=16'hFFFE, read_len=3 -> data_addr_in sequence FFFE, FFFF, 0000 (wrap).
- abort asserted mid-LOAD after 2 of 8 beats, plus a start pulse while busy -> IDLE/status 00 next cycle; the busy-time start has no effect; a fresh start re-runs from address 0.
